// File: rtl/aq_mmu_jtlb_sram_ctrl.sv
// jTLB SRAM access controller: arbitrates masked writes and reads into the
// 64x98 single-port array and runs full-array invalidate sweeps.
module aq_mmu_jtlb_sram_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 98,
  parameter int DEPTH      = 64,
  parameter int INV_ON_RST = 1
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst,
  input  logic                  inv_all_req,
  output logic                  inv_all_done,
  output logic                  busy,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_mask,
  output logic                  wr_ack,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_idx,
  output logic                  rd_ack,
  output logic                  rd_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  typedef enum logic {S_IDLE, S_INV} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_d;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_done;
  logic                  r_rvld;
  logic                  r_post;

  logic w_inv_req;
  logic w_idle;
  logic w_wack;
  logic w_rack;
  logic w_last;

  // r_post marks the first cycle out of reset, which acts as an invalidate request
  assign w_inv_req = inv_all_req | ((INV_ON_RST != 0) & r_post);
  assign w_idle    = (r_state == S_IDLE) & ~cpurst;
  assign w_wack    = w_idle & wr_req & ~w_inv_req;
  assign w_rack    = w_idle & rd_req & ~wr_req & ~w_inv_req;
  assign w_last    = (r_cnt == ADDR_WIDTH'(DEPTH - 1));

  assign wr_ack       = w_wack;
  assign rd_ack       = w_rack;
  assign busy         = (r_state == S_INV) & ~cpurst;
  assign inv_all_done = r_done & ~cpurst;
  assign rd_vld       = r_rvld & ~cpurst;
  // SRAM data arrives the cycle after the read, so it is bypassed onto rd_data
  // in the valid cycle and captured into r_rdata for the hold cycles after
  assign rd_data      = cpurst ? '0 : (r_rvld ? sram_q : r_rdata);

  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = r_a;
    sram_d    = r_d;
    if (cpurst) begin
      sram_a = '0;
      sram_d = '0;
    end else if (r_state == S_INV) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = r_cnt;
      sram_d    = '0;
    end else if (w_wack) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = ~wr_mask;
      sram_a    = wr_idx;
      sram_d    = wr_data;
    end else if (w_rack) begin
      sram_cen  = 1'b0;
      sram_a    = rd_idx;
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_d     <= '0;
      r_rdata <= '0;
      r_done  <= 1'b0;
      r_rvld  <= 1'b0;
      r_post  <= 1'b1;
    end else begin
      r_post <= 1'b0;
      r_done <= 1'b0;
      r_rvld <= w_rack;
      if (r_rvld) r_rdata <= sram_q;
      case (r_state)
        S_IDLE: begin
          if (w_inv_req) begin
            r_state <= S_INV;
            r_cnt   <= '0;
          end else if (w_wack) begin
            r_a <= wr_idx;
            r_d <= wr_data;
          end else if (w_rack) begin
            r_a <= rd_idx;
          end
        end
        S_INV: begin
          r_a <= r_cnt;
          r_d <= '0;
          if (w_last) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/aq_mmu_jtlb_sram_ctrl.md
# aq_mmu_jtlb_sram_ctrl

Access controller sitting directly upstream of the jTLB 64x98 single-port SRAM wrapper in the MMU. Arbitrates read and masked-write requests from the jTLB logic and runs a full-array invalidate sweep, on request or after reset. Drives the SRAM's active-low control pins and returns read data one cycle after acceptance. It is the only master of the SRAM; nothing else may drive its pins.

## Interface
Parameters:
- ADDR_WIDTH, 6, SRAM index width.
- DATA_WIDTH, 98, SRAM word width and write-mask width.
- DEPTH, 64, entry count; must equal 2**ADDR_WIDTH.
- INV_ON_RST, 1, 1 = start an invalidate sweep automatically when reset deasserts.

Ports:
- forever_cpuclk  in  1  clock; the only clock.
- cpurst  in  1  reset, synchronous, active-high.
- inv_all_req  in  1  level request to zero every entry.
- inv_all_done  out  1  one-cycle pulse when a sweep completes.
- busy  out  1  high while a sweep is in progress.
- wr_req  in  1  write request.
- wr_idx  in  ADDR_WIDTH  write index.
- wr_data  in  DATA_WIDTH  write data.
- wr_mask  in  DATA_WIDTH  per-bit write enable, 1 = write this bit.
- wr_ack  out  1  write accepted this cycle (combinational).
- rd_req  in  1  read request.
- rd_idx  in  ADDR_WIDTH  read index.
- rd_ack  out  1  read accepted this cycle (combinational).
- rd_vld  out  1  rd_data carries a new read result.
- rd_data  out  DATA_WIDTH  read result; held between reads.
- sram_cen  out  1  SRAM chip enable, active-low.
- sram_gwen  out  1  SRAM global write enable, active-low.
- sram_wen  out  DATA_WIDTH  SRAM bit write enable, active-low.
- sram_a  out  ADDR_WIDTH  SRAM address.
- sram_d  out  DATA_WIDTH  SRAM write data.
- sram_q  in  DATA_WIDTH  SRAM read data, valid the cycle after a read access.

## Operation
- FSM states: IDLE, INV.
  - IDLE -> INV when inv_all_req is high.
  - INV -> IDLE after the access at index DEPTH-1.
- While cpurst is high, all outputs and state take reset values.
- Reset values:
  - State IDLE, sweep counter 0.
  - inv_all_done 0, busy 0, rd_vld 0, rd_data 0.
  - wr_ack 0, rd_ack 0.
  - sram_cen 1, sram_gwen 1, sram_wen all-1, sram_a 0, sram_d 0.
- Post-reset sweep: if INV_ON_RST=1, the first cycle after cpurst falls behaves as if inv_all_req were high.
- IDLE priority, all evaluated in the same cycle: invalidate > write > read.
  - wr_ack = IDLE & wr_req & ~inv_all_req.
  - rd_ack = IDLE & rd_req & ~wr_req & ~inv_all_req.
  - A refused request gets no ack. The requester must hold the request; the controller does not queue it.
- Accepted write, same cycle:
  - sram_cen=0, sram_gwen=0, sram_a=wr_idx, sram_d=wr_data, sram_wen=~wr_mask.
  - An all-zero wr_mask is still a legal write: it is acked and changes no bits.
- Accepted read, same cycle: sram_cen=0, sram_gwen=1, sram_wen all-1, sram_a=rd_idx.
- Idle cycle with no accepted access: sram_cen=1, sram_gwen=1, sram_wen all-1. sram_a and sram_d hold their last values.
- INV state, each cycle:
  - sram_cen=0, sram_gwen=0, sram_wen all-0, sram_d=0, sram_a=counter.
  - Counter increments by 1 each cycle, from 0 to DEPTH-1, with no wrap.
  - busy=1.
  - No acks; inv_all_req is ignored.
- Read return:
  - On the cycle after rd_ack, rd_vld=1 and rd_data is loaded from sram_q in that cycle. rd_data is a register that also drives the output in that cycle.
  - In all other cycles rd_vld=0 and rd_data holds its value.
- Mid-sweep reset: the sweep is aborted with no done pulse. The array contents are undefined, and a new sweep follows if INV_ON_RST=1.

## Timing
- Write: the request is accepted in cycle T and the SRAM writes at the end of T. A read of the same index accepted in T+1 returns the new data at T+2.
- Read latency: rd_ack in T, rd_vld and rd_data in T+1. Back-to-back reads give one result per cycle.
- Sweep length:
  - inv_all_req in IDLE cycle T puts the controller in INV for cycles T+1 .. T+DEPTH, with indices 0..DEPTH-1.
  - In cycle T+DEPTH+1: state is IDLE, inv_all_done=1, busy=0, and acks are possible again.
  - An invalidate accepted in T causes no SRAM access in T.
- A read acked in cycle T-1 still returns rd_vld in T, even if the sweep is requested in T.
- Re-issue: inv_all_req held high through inv_all_done starts a new sweep on the done cycle; that cycle grants no acks.

## Test plan
- Reset with INV_ON_RST=1:
  - Deassert cpurst at cycle 0; cycles 1..64 show sram_a=0..63 with cen=0, gwen=0, d=0.
  - inv_all_done pulses at cycle 65, busy falls, and outputs match reset values during reset.
- Write then read:
  - Write idx 5, data 0x3_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, mask all-1; read idx 5 the next cycle.
  - rd_vld is asserted 1 cycle after rd_ack, with rd_data equal to the written data.
- Masked write: over existing data 0, write data all-1 with mask 0x0F. A read returns 0x0F.
- Same-cycle priority:
  - wr_req and rd_req together: wr_ack=1, rd_ack=0, read held and acked the next cycle.
  - inv_all_req with both: neither acked, and the sweep starts next cycle.
- Sweep clears data: write nonzero to idx 0, 31 and 63, run inv_all_req, then read all three; each returns 0.
- Reset mid-sweep:
  - Assert cpurst at sweep index 20: no inv_all_done, and outputs take reset values.
  - After release, a full 64-entry sweep runs.
